sum_accumulator: RTL and testbench

Downstream consumer of the registered two-operand adder stage.
- Takes the adder's (WIDTH+1)-bit results as a valid/ready stream.
- Accumulates NUM_SAMPLES consecutive results into one block sum and presents it on a registered valid/ready output.
- Sits between the adder and the result sink. The integrator delays in_valid by one cycle to align it with the adder's registered output.

---
 rtl/sum_pkg.sv | 12 +
 rtl/sum_accumulator.sv | 103 ++++++++++
 tb/tb_sum_accumulator.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sum_pkg.sv
// Shared types and helpers for the block-sum accumulator.
// Used by sum_accumulator and the adder stage's integration.
package sum_pkg;

   typedef enum logic {ACCUM, HOLD} sum_acc_state_t;

   // Accumulator width: adder result plus log2(n) guard bits.
   function automatic int acc_width(input int width, input int n);
      return width + 1 + $clog2(n);
   endfunction

endpackage

// File: rtl/sum_accumulator.sv
// Sums NUM_SAMPLES adder results into one block sum on a valid/ready output.
// Optional rounded block mean on out_avg when SUM_ACC_AVG_EN is defined.
module sum_accumulator
   import sum_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NUM_SAMPLES = 4,
   localparam int ACC_WIDTH = acc_width(WIDTH, NUM_SAMPLES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH:0]       in_data,
   input  logic                 clear,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum
`ifdef SUM_ACC_AVG_EN
   ,
   output logic [WIDTH:0]       out_avg
`endif
);

   localparam int CW = $clog2(NUM_SAMPLES);

   sum_acc_state_t       state;
   logic [ACC_WIDTH-1:0] acc;
   logic [CW-1:0]        cnt;
   logic [ACC_WIDTH-1:0] data_ext;
   logic [ACC_WIDTH-1:0] sum_next;
   logic                 accept;
   logic                 last;

   assign in_ready = !rst && !clear && (state == ACCUM || out_ready);
   assign accept   = in_valid && in_ready;
   assign data_ext = ACC_WIDTH'(in_data);
   assign sum_next = acc + data_ext;
   assign last     = (cnt == CW'(NUM_SAMPLES - 1));

`ifdef SUM_ACC_AVG_EN
   logic [ACC_WIDTH-1:0] rnd;
   logic [WIDTH:0]       avg_next;

   // Round half up, then divide by the power-of-two block size.
   always_comb begin
      rnd      = sum_next + ACC_WIDTH'(NUM_SAMPLES / 2);
      avg_next = rnd[ACC_WIDTH-1:CW];
   end
`endif

   // Block FSM: accumulate in ACCUM, hold the result in HOLD until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
`ifdef SUM_ACC_AVG_EN
         out_avg   <= '0;
`endif
      end else begin
         // clear forces in_ready low, so no accept below can collide.
         if (clear) begin
            acc <= '0;
            cnt <= '0;
         end
         unique case (state)
            ACCUM: begin
               if (accept) begin
                  if (last) begin
                     out_sum   <= sum_next;
`ifdef SUM_ACC_AVG_EN
                     out_avg   <= avg_next;
`endif
                     out_valid <= 1'b1;
                     acc       <= '0;
                     cnt       <= '0;
                     state     <= HOLD;
                  end else begin
                     acc <= sum_next;
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ACCUM;
                  // Pass-through: the sample taken now starts the next block.
                  if (accept) begin
                     acc <= data_ext;
                     cnt <= CW'(1);
                  end
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator (WIDTH=8, NUM_SAMPLES=4).
// out_avg checks are compiled only when SUM_ACC_AVG_EN is defined.
module tb_sum_accumulator;

   localparam int WIDTH = 8;
   localparam int NS = 4;
   localparam int AW = WIDTH + 1 + $clog2(NS);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [WIDTH:0] in_data;
   logic          clear;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_sum;
`ifdef SUM_ACC_AVG_EN
   logic [WIDTH:0] out_avg;
`endif

   int checks = 0;
   int failures = 0;

   sum_accumulator #(.WIDTH(WIDTH), .NUM_SAMPLES(NS)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .clear(clear),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum(out_sum)
`ifdef SUM_ACC_AVG_EN
      ,
      .out_avg(out_avg)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int d);
      in_valid = 1'b1;
      in_data  = (WIDTH+1)'(d);
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_data  = '0;
      tick();
   endtask

   task automatic out_chk(input string tag, input int v, input int s,
                          input int a);
      chk({tag, "_valid"}, int'(out_valid), v);
      chk({tag, "_sum"}, int'(out_sum), s);
`ifdef SUM_ACC_AVG_EN
      chk({tag, "_avg"}, int'(out_avg), a);
`else
      if (a < 0) $display("unused avg %0d", a);
`endif
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 9'd5;
      clear = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("rst_in_ready", int'(in_ready), 0);
      tick();
      tick();
      chk("rst_in_ready2", int'(in_ready), 0);
      out_chk("rst", 0, 0, 0);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("post_rst_ready", int'(in_ready), 1);

      // 1: back-to-back 10,20,30,40
      send(10);
      send(20);
      send(30);
      chk("t1_not_yet", int'(out_valid), 0);
      send(40);
      out_chk("t1", 1, 100, 25);
      idle();
      chk("t1_drop", int'(out_valid), 0);

      // 2: max input, no wrap
      send(510);
      send(510);
      send(510);
      send(510);
      out_chk("t2", 1, 2040, 510);
      idle();
      chk("t2_drop", int'(out_valid), 0);

      // 3: stall with next sample pending, then pass-through
      out_ready = 1'b0;
      send(1);
      send(2);
      send(3);
      send(4);
      out_chk("t3", 1, 10, 3);
      in_valid = 1'b1;
      in_data = 9'd7;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_stall_ready", int'(in_ready), 0);
         tick();
         out_chk("t3_stall", 1, 10, 3);
      end
      out_ready = 1'b1;
      #1;
      chk("t3_pass_ready", int'(in_ready), 1);
      tick();
      chk("t3_pass_drop", int'(out_valid), 0);
      send(1);
      send(1);
      chk("t3b_not_yet", int'(out_valid), 0);
      send(1);
      out_chk("t3b", 1, 10, 3);
      idle();
      chk("t3b_drop", int'(out_valid), 0);

      // 4: clear discards partial block
      send(5);
      send(6);
      in_valid = 1'b1;
      in_data = 9'd99;
      clear = 1'b1;
      #1;
      chk("t4_clear_ready", int'(in_ready), 0);
      tick();
      clear = 1'b0;
      send(1);
      send(2);
      send(3);
      send(4);
      out_chk("t4", 1, 10, 3);
      idle();
      send(1);
      send(1);
      send(1);
      out_ready = 1'b0;
      send(1);
      out_chk("t4b", 1, 4, 1);
      in_valid = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      out_chk("t4_clear_hold", 1, 4, 1);
      out_ready = 1'b1;
      tick();
      chk("t4b_drop", int'(out_valid), 0);

      // 5: reset mid-block
      send(9);
      send(9);
      send(9);
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 9'd9;
      #1;
      chk("t5_rst_ready", int'(in_ready), 0);
      tick();
      rst = 1'b0;
      out_chk("t5_rst", 0, 0, 0);
      send(2);
      send(2);
      send(2);
      chk("t5_not_yet", int'(out_valid), 0);
      send(2);
      out_chk("t5", 1, 8, 2);

      // 6: back-to-back blocks, rounding of the mean
      send(1);
      chk("t6_pass_drop", int'(out_valid), 0);
      send(1);
      send(0);
      send(0);
      out_chk("t6a", 1, 2, 1);
      send(1);
      send(0);
      send(0);
      send(0);
      out_chk("t6b", 1, 1, 0);
      send(1);
      send(1);
      send(1);
      send(0);
      out_chk("t6c", 1, 3, 1);
      idle();
      chk("t6_drop", int'(out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
